// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin result-bus arbiter.
//   NUM_REQ / SEL_W / DATA_W : requester count, select width, word width
//   S_IDLE / S_XFER          : arbiter state encodings
//   mux8                     : 8:1 word mux feeding the out_data capture register
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 16;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  function automatic logic [DATA_W-1:0] mux8(
    input logic [NUM_REQ*DATA_W-1:0] d,
    input logic [SEL_W-1:0]          s
  );
    return d[s*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo 8.
//   req   : request vector
//   ptr   : highest-priority index for this decision
//   idx   : chosen requester (valid only when found=1)
//   found : at least one request present
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W:0]     lsh;
  logic [SEL_W-1:0]   off;

  // Rotate so that requester ptr lands at bit 0; a left shift by 8 (ptr=0) yields zero.
  assign lsh = (SEL_W+1)'(NUM_REQ) - {1'b0, ptr};
  assign rot = (req >> ptr) | (req << lsh);

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
  end

  // Un-rotate; the 3-bit add wraps naturally.
  assign idx = ptr + off;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one result bus between 8 requesters.
//   clk, rst    : clock, synchronous active-high reset
//   req,data_in : per-requester request level and word (requester i at [i*DATA_W +: DATA_W])
//   gnt, sel    : registered one-hot grant and its index
//   ack         : one-hot handshake pulse for the granted requester
//   out_data, out_valid, out_ready : downstream valid/ready interface
//   busy        : transfer in progress
//
// state  | meaning
// S_IDLE | waiting for any request; picks next owner in ptr order
// S_XFER | word captured, holding out_valid until out_ready
module rr_mux_arbiter #(
  parameter  int DATA_W  = 16,
  parameter  int NUM_REQ = 8,
  localparam int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          sel,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  import arb_pkg::*;

  logic [0:0]       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             hshk;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign hshk = out_valid & out_ready;
  assign ack  = gnt & {NUM_REQ{hshk}};
  assign busy = (state == S_XFER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            gnt       <= NUM_REQ'(1) << pick_idx;
            sel       <= pick_idx;
            out_data  <= mux8(data_in, pick_idx);
            out_valid <= 1'b1;
            state     <= S_XFER;
          end
        end
        default: begin
          if (hshk) begin
            // Granted port drops to lowest priority; sel is kept for observation.
            out_valid <= 1'b0;
            gnt       <= '0;
            ptr       <= sel + 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   req;
  logic [127:0] data_in;
  logic [7:0]   gnt;
  logic [2:0]   sel;
  logic [7:0]   ack;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int ncmp  = 0;
  int nfail = 0;

  rr_mux_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .sel       (sel),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input int p, input logic [15:0] w, input logic [7:0] a);
    chk({tag, ".gnt"}, 32'(gnt), 32'(8'h01 << p));
    chk({tag, ".sel"}, 32'(sel), 32'(p));
    chk({tag, ".data"}, 32'(out_data), 32'(w));
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".ack"}, 32'(ack), 32'(a));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".gnt"}, 32'(gnt), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".ack"}, 32'(ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = 8'hFF;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) data_in[i*16 +: 16] = 16'hA000 + 16'(i);

    // Reset held two cycles with all requests asserted
    tick();
    tick();
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.sel", 32'(sel), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);

    // Rotation: grants 0..7 then 0, one word every 2 cycles
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_grant($sformatf("rot%0d", k), k % 8, 16'hA000 + 16'(k % 8), 8'h01 << (k % 8));
      tick();
      chk_idle($sformatf("rot%0d.idle", k));
    end

    // No requests: outputs hold
    req = 8'h00;
    tick();
    tick();
    chk_idle("noreq");
    chk("noreq.sel", 32'(sel), 32'd0);
    chk("noreq.data", 32'(out_data), 32'hA000);

    // Single request on port 3
    data_in[3*16 +: 16] = 16'hBEEF;
    req = 8'h08;
    tick();
    chk_grant("single", 3, 16'hBEEF, 8'h08);
    req = 8'h00;
    tick();
    chk_idle("single.done");
    chk("single.selhold", 32'(sel), 32'd3);

    // Backpressure on port 5; req and data dropped after grant
    data_in[5*16 +: 16] = 16'h5A5A;
    req = 8'h20;
    out_ready = 1'b0;
    tick();
    chk_grant("bp", 5, 16'h5A5A, 8'h00);
    req = 8'h00;
    data_in[5*16 +: 16] = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_grant($sformatf("bp.hold%0d", c), 5, 16'h5A5A, 8'h00);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.ack", 32'(ack), 32'h20);
    tick();
    chk_idle("bp.done");

    // Wrap and skip: ptr 6 -> grant 6 -> ptr 7; then req 0x41 gives 0 then 6
    data_in[0*16 +: 16] = 16'h1111;
    data_in[6*16 +: 16] = 16'h6666;
    data_in[7*16 +: 16] = 16'h7777;
    req = 8'h40;
    tick();
    chk_grant("wrap.g6", 6, 16'h6666, 8'h40);
    req = 8'h00;
    tick();
    chk_idle("wrap.idle0");
    req = 8'h41;
    tick();
    chk_grant("wrap.g0", 0, 16'h1111, 8'h01);
    tick();
    chk_idle("wrap.idle1");
    tick();
    chk_grant("wrap.g6b", 6, 16'h6666, 8'h40);
    req = 8'h00;
    tick();
    chk_idle("wrap.idle2");

    // Reset mid-transfer; ptr is 7 here, so a post-reset pick of 0 proves ptr cleared
    data_in[4*16 +: 16] = 16'h4444;
    req = 8'h10;
    out_ready = 1'b0;
    tick();
    chk_grant("rstx", 4, 16'h4444, 8'h00);
    rst = 1'b1;
    #1;
    chk("rstx.ack", 32'(ack), 32'd0);
    tick();
    chk_idle("rstx.after");
    chk("rstx.data", 32'(out_data), 32'd0);
    chk("rstx.sel", 32'(sel), 32'd0);
    rst = 1'b0;
    req = 8'hFF;
    out_ready = 1'b1;
    tick();
    chk_grant("rstx.ptr0", 0, 16'h1111, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
